// File: rtl/pong_input_hub.sv
// pong_input_hub: N-channel player input front end, fully synchronous to CLK.
// Per channel it synchronises and debounces a quadrature encoder and a push button,
// decodes x4 quadrature steps and keeps a saturating paddle position. It also produces
// the single-cycle SAMPLE_TICK / GAME_TICK enables and the LED heartbeat.
//
// Ports:
//   CLK          system clock
//   RST_N        asynchronous reset, active low
//   ENC_QA       [N_CH]        encoder phase A per channel (asynchronous)
//   ENC_QB       [N_CH]        encoder phase B per channel (asynchronous)
//   BUTTON       [N_CH]        push buttons, active high (asynchronous)
//   UP           [N_CH]        one-cycle pulse per forward step
//   DOWN         [N_CH]        one-cycle pulse per reverse step
//   BTN_PRESS    [N_CH]        one-cycle pulse on debounced button rising edge
//   POSITION     [N_CH*POS_W]  channel i position at [i*POS_W +: POS_W]
//   SAMPLE_TICK  one-cycle enable every SAMPLE_DIV cycles
//   GAME_TICK    one-cycle enable every SAMPLE_DIV*FSM_DIV cycles
//   LED          [4]           GAME_TICK count modulo 16
module pong_input_hub #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned SAMPLE_DIV = 75000,
  parameter int unsigned FSM_DIV    = 16,
  parameter int unsigned DEB_LEN    = 4,
  parameter int unsigned POS_W      = 11,
  parameter int unsigned POS_MIN    = 0,
  parameter int unsigned POS_MAX    = 15,
  parameter int unsigned POS_INIT   = 7,
  parameter int unsigned STEP       = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N_CH-1:0]       ENC_QA,
  input  logic [N_CH-1:0]       ENC_QB,
  input  logic [N_CH-1:0]       BUTTON,
  output logic [N_CH-1:0]       UP,
  output logic [N_CH-1:0]       DOWN,
  output logic [N_CH-1:0]       BTN_PRESS,
  output logic [N_CH*POS_W-1:0] POSITION,
  output logic                  SAMPLE_TICK,
  output logic                  GAME_TICK,
  output logic [3:0]            LED
);

  localparam int unsigned PresW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned GameW = (FSM_DIV > 1) ? $clog2(FSM_DIV) : 1;
  localparam int unsigned DcntW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam int unsigned NBits = 3 * N_CH;
  localparam int unsigned PosWx = POS_W + 1;

  // Position arithmetic is one bit wider so neither clamp can wrap.
  localparam logic [POS_W:0]   StepX       = PosWx'(STEP);
  localparam logic [POS_W:0]   MinPlusStep = PosWx'(POS_MIN + STEP);
  localparam logic [POS_W:0]   MaxX        = PosWx'(POS_MAX);
  localparam logic [POS_W-1:0] PosMin      = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] PosMax      = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] PosInit     = POS_W'(POS_INIT);

  // Gray position of a quadrature state along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
    logic [POS_W:0] ext;
    ext = {1'b0, p};
    if (ext < MinPlusStep) pos_dec = PosMin;
    else                   pos_dec = POS_W'(ext - StepX);
  endfunction

  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    logic [POS_W:0] sum;
    sum = {1'b0, p} + StepX;
    if (sum > MaxX) pos_inc = PosMax;
    else            pos_inc = POS_W'(sum);
  endfunction

  // ---------------- timebase ----------------
  logic [PresW-1:0] pres_q;
  logic [GameW-1:0] game_q;
  logic [3:0]       led_q;
  logic             sample_tick;
  logic             game_tick;

  assign sample_tick = (pres_q == PresW'(SAMPLE_DIV - 1));
  assign game_tick   = sample_tick && (game_q == GameW'(FSM_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pres_q <= '0;
      game_q <= '0;
      led_q  <= '0;
    end else begin
      pres_q <= sample_tick ? '0 : pres_q + PresW'(1);
      if (sample_tick) game_q <= game_tick ? '0 : game_q + GameW'(1);
      if (game_tick)   led_q  <= led_q + 4'd1;
    end
  end

  // ---------------- synchroniser + debounce ----------------
  // Bit layout: QA at [i], QB at [N_CH+i], BUTTON at [2*N_CH+i].
  logic [NBits-1:0]            raw;
  logic [NBits-1:0]            sync1_q, sync2_q;
  logic [NBits-1:0]            deb_q, deb_d;
  logic [NBits-1:0][DcntW-1:0] dcnt_q, dcnt_d;

  assign raw = {BUTTON, ENC_QB, ENC_QA};

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (sample_tick) begin
      for (int i = 0; i < NBits; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_d[i] = '0;
        end else if (dcnt_q[i] == DcntW'(DEB_LEN - 1)) begin
          deb_d[i]  = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DcntW'(1);
        end
      end
    end
  end

  // ---------------- decode + position ----------------
  // Decoding compares the current debounced level with its next value, so pulses and
  // position updates land on the same edge that accepts a new level.
  logic [N_CH-1:0]             up_d, down_d, btn_d;
  logic [N_CH-1:0]             up_q, down_q, btn_q;
  logic [N_CH-1:0][POS_W-1:0]  pos_q, pos_d;

  always_comb begin
    up_d   = '0;
    down_d = '0;
    btn_d  = '0;
    pos_d  = pos_q;
    for (int i = 0; i < N_CH; i++) begin
      logic [1:0] delta;
      delta = gray_idx({deb_d[i], deb_d[N_CH+i]}) - gray_idx({deb_q[i], deb_q[N_CH+i]});
      // delta of 2 is a two-bit jump and is ignored.
      up_d[i]   = (delta == 2'd1);
      down_d[i] = (delta == 2'd3);
      btn_d[i]  = deb_d[2*N_CH+i] & ~deb_q[2*N_CH+i];
      if (up_d[i])        pos_d[i] = pos_dec(pos_q[i]);
      else if (down_d[i]) pos_d[i] = pos_inc(pos_q[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
      up_q    <= '0;
      down_q  <= '0;
      btn_q   <= '0;
      pos_q   <= {N_CH{PosInit}};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      up_q    <= up_d;
      down_q  <= down_d;
      btn_q   <= btn_d;
      pos_q   <= pos_d;
    end
  end

  assign UP          = up_q;
  assign DOWN        = down_q;
  assign BTN_PRESS   = btn_q;
  assign POSITION    = pos_q;
  assign SAMPLE_TICK = sample_tick;
  assign GAME_TICK   = game_tick;
  assign LED         = led_q;

endmodule
